// File: rtl/i_cache_control.sv
// Instruction-cache miss controller: on a read miss it fetches the line from
// main memory, then pulses the valid/tag/data load-enables for one cycle.
module i_cache_control (
  input  logic clk,
  input  logic rst_n,
  input  logic cache_read,
  input  logic mmem_status,
  input  logic hit,
  output logic mmem_r,
  output logic v,
  output logic tag,
  output logic data
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    FETCH    = 2'b01,
    ALLOCATE = 2'b10
  } state_t;

  state_t state;
  logic   fill;

  // Outputs are registered together with the state and always loaded with the
  // values that belong to the state being entered. They therefore depend only
  // on the registered state and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mmem_r <= 1'b0;
      fill   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // pre-edge values, so state and outputs cannot race each other.
      case (state)
        IDLE: begin
          // A hit is served combinationally by the datapath. When cache_read
          // is low, hit may be X and must not be able to start a fetch.
          if (cache_read && !hit) begin
            state  <= FETCH;
            mmem_r <= 1'b1;
            fill   <= 1'b0;
          end else begin
            state  <= IDLE;
            mmem_r <= 1'b0;
            fill   <= 1'b0;
          end
        end

        FETCH: begin
          // cache_read is deliberately ignored here: a started fill always
          // runs to completion.
          if (mmem_status) begin
            state  <= ALLOCATE;
            mmem_r <= 1'b0;
            fill   <= 1'b1;
          end else begin
            state  <= FETCH;
            mmem_r <= 1'b1;
            fill   <= 1'b0;
          end
        end

        ALLOCATE: begin
          state  <= IDLE;
          mmem_r <= 1'b0;
          fill   <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          mmem_r <= 1'b0;
          fill   <= 1'b0;
        end
      endcase
    end
  end

  // A single flop drives all three load-enables, so they can never disagree.
  assign v    = fill;
  assign tag  = fill;
  assign data = fill;

endmodule

// File: tb/tb_i_cache_control.sv
// Scoreboard bench for i_cache_control: a transaction-level model predicts
// each cycle's outputs and a separate monitor compares them with the DUT.
module tb_i_cache_control;

  logic clk = 1'b0;
  logic rst_n;
  logic cache_read;
  logic mmem_status;
  logic hit;
  logic mmem_r;
  logic v;
  logic tag;
  logic data;

  int total = 0;
  int bad   = 0;

  // Expected {mmem_r, v, tag, data} after each rising edge.
  logic [3:0] exp_q[$];

  // Reference model state, in terms of the request being served.
  bit line_requested;
  bit line_arrived;
  bit done;

  always #5 clk = ~clk;

  i_cache_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cache_read  (cache_read),
    .mmem_status (mmem_status),
    .hit         (hit),
    .mmem_r      (mmem_r),
    .v           (v),
    .tag         (tag),
    .data        (data)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {mmem_r,v,tag,data}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a miss makes the line "requested"; while requested, the memory read
  // strobe is up; once memory reports the line, the cache is written exactly
  // once on the following cycle; only then is a new request possible.
  always @(posedge clk) begin
    if (!rst_n) begin
      line_requested = 1'b0;
      line_arrived   = 1'b0;
    end else if (line_arrived) begin
      line_arrived = 1'b0;
    end else if (line_requested) begin
      if (mmem_status) begin
        line_requested = 1'b0;
        line_arrived   = 1'b1;
      end
    end else if (cache_read && !hit) begin
      line_requested = 1'b1;
    end
    exp_q.push_back({line_requested, line_arrived, line_arrived, line_arrived});
  end

  // Monitor: samples the outputs 1 time unit after every rising edge.
  always begin
    @(posedge clk);
    #1;
    if (!done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
        check("cycle", {mmem_r, v, tag, data}, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic cr, input logic h, input logic ms);
    @(negedge clk);
    cache_read  = cr;
    hit         = h;
    mmem_status = ms;
  endtask

  // Asserts reset away from any edge and checks outputs drop without a clock.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(name, {mmem_r, v, tag, data}, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    done        = 1'b0;
    rst_n       = 1'b0;
    cache_read  = 1'b0;
    hit         = 1'b0;
    mmem_status = 1'b0;
    #1;
    check("reset_initial", {mmem_r, v, tag, data}, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Miss, memory busy for three cycles, then line available.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Hit for two cycles: nothing happens.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Abort attempt: cache_read drops right after mmem_r rises.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Stuck status held high through and after the allocate.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // Pending read re-evaluated after allocate: misses again, then hits.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a fetch.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    async_reset("reset_mid_fetch");
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // Reset during the allocate cycle.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_mid_allocate", {mmem_r, v, tag, data}, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset("reset_random");
      end else begin
        cyc(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
      end
    end

    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i_cache_control.md
I_CACHE_CONTROL -- requirements
Module: i_cache_control

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low; ports clk and rst_n.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: cache_read  input  1  datapath requests an instruction read this cycle.
REQ-005 Port: mmem_status  input  1  main memory response; 1 = requested line is available on the memory data bus.
REQ-006 Port: mmem_r  output  1  read strobe to main memory.
REQ-007 Port: v  output  1  load-enable for the addressed valid bit (writes 1).
REQ-008 Port: tag  output  1  load-enable for the addressed tag entry.
REQ-009 Port: data  output  1  load-enable for the addressed data line.
REQ-010 Port: hit  input  1  datapath tag-compare result (valid and tag match) for the current address.
REQ-011 No parameters; all ports are scalar.

Function
REQ-012 Control SHALL be a Moore FSM with states IDLE, FETCH, ALLOCATE; 2-bit state register; outputs decoded only from the registered state.
REQ-013 IDLE: all outputs 0; cache_read=1 and hit=1 -> stay IDLE (hit served combinationally by the datapath); cache_read=1 and hit=0 -> FETCH; cache_read=0 -> stay IDLE, hit ignored (may be X).
REQ-014 FETCH: mmem_r=1, v=tag=data=0; mmem_status=0 -> stay FETCH; mmem_status=1 -> ALLOCATE.
REQ-015 ALLOCATE: mmem_r=0, v=tag=data=1 for exactly one cycle; unconditional return to IDLE.
REQ-016 Miss latency: mmem_r asserts 1 cycle after the miss is sampled; the allocate pulse asserts 1 cycle after mmem_status is sampled high.
REQ-017 cache_read dropping during FETCH SHALL NOT abort the fill; the fill always completes through ALLOCATE.
REQ-018 mmem_status high in IDLE or ALLOCATE SHALL be ignored; mmem_status held high across ALLOCATE SHALL NOT start another fetch.
REQ-019 After ALLOCATE, a still-pending cache_read SHALL be re-evaluated in IDLE; hit=1 then completes it, and hit=0 starts a new FETCH.
REQ-020 v, tag and data SHALL always be equal, and SHALL never be 1 in the same cycle as mmem_r.
REQ-021 Unreachable state encoding SHALL transition to IDLE with all outputs 0.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock edge, force state to IDLE and mmem_r, v, tag and data to 0.
REQ-023 Reset asserted mid-FETCH or mid-ALLOCATE SHALL abandon the operation with no allocate pulse; after release, the FSM SHALL start from IDLE on the next rising edge.

Verification
REQ-024 Reset: drive rst_n=0 at arbitrary time -> all outputs 0 within the same timestep; state IDLE.
REQ-025 Miss: cache_read=1, hit=0, mmem_status=0 for 3 cycles, then mmem_status=1 -> mmem_r=1 from cycle 1 through the cycle mmem_status is sampled; next cycle v=tag=data=1 and mmem_r=0 for one cycle; then IDLE.
REQ-026 Hit: cache_read=1, hit=1, mmem_status=0 for 2 cycles -> mmem_r=v=tag=data=0 throughout; state stays IDLE.
REQ-027 Abort attempt: miss begins, cache_read=0 on the cycle after mmem_r rises, mmem_status=1 two cycles later -> allocate pulse still occurs exactly once.
REQ-028 Stuck status: mmem_status=1 held for 4 cycles after the fill with cache_read=0 -> single allocate pulse; mmem_r stays 0 afterwards.
REQ-029 Reset mid-fill: rst_n=0 while in FETCH -> mmem_r drops immediately; no v/tag/data pulse after release.
